sdram_pattern_tester: RTL and testbench
=======================================

Name: sdram_pattern_tester

Overview:
- Parametrised successor to the fixed 16-word write/wait/read SDRAM test loop.
- Drives a simple SDRAM controller through its wrreq/rereq/rwdone/rw_busy handshake.
- Writes a selectable data pattern over a configurable address window, waits, reads the window back and compares every word.
- Reports pass and error counts, a sticky error flag and a handshake timeout; instantiated beside sdram_con2 under the board top level.

Parameters:
- ADDR_W, 23, controller word-address width.
- DATA_W, 16, data width (1..32).
- BASE_ADDR, 0, first address of the test window.
- BURST_LEN, 16, words per phase (>=1; BASE_ADDR+BURST_LEN-1 must fit ADDR_W).
- GAP_CYCLES, 50000000, idle cycles between phases (>=1).
- TIMEOUT, 1024, max cycles from request to rwdone.
- SEED, 16'hACE1, LFSR seed (nonzero).

Ports:
- CLOCK_50  in  1  system clock; all logic on posedge.
- RST_N  in  1  synchronous active-low reset.
- start  in  1  level; high in IDLE starts looping, low stops at end of current pass.
- mode  in  2  pattern select: 0 addr, 1 ~addr, 2 walking-one, 3 LFSR.
- addr  out  ADDR_W  controller address.
- wrreq  out  1  write request.
- rereq  out  1  read request.
- wdata  out  DATA_W  write data.
- rdata  in  DATA_W  read data, valid in the cycle rwdone=1.
- rwdone  in  1  access-complete pulse.
- rw_busy  in  1  controller busy.
- phase  out  2  0 write, 1 gap, 2 read, 3 gap.
- active  out  1  high outside IDLE.
- error  out  1  sticky; set on mismatch or timeout, cleared only by reset.
- timeout  out  1  sticky; handshake timeout seen.
- err_count  out  16  mismatching words, saturates at 16'hFFFF.
- pass_count  out  16  completed error-free passes, saturates at 16'hFFFF.

Behaviour:
- Reset (RST_N=0 at a clock edge), also mid-operation: FSM to IDLE. Outputs after that edge: wrreq=0, rereq=0, addr=BASE_ADDR, wdata=0, phase=0, active=0, error=0, timeout=0, both counters 0, LFSR=SEED.
- FSM states: IDLE, ISSUE, WAITDONE, NEXT, GAP.
- IDLE -> ISSUE when start=1. Sample mode; addr=BASE_ADDR; phase=0; LFSR=SEED.
- ISSUE: when rw_busy=0, assert wrreq (phase 0) or rereq (phase 2) and go to WAITDONE. Otherwise hold.
- WAITDONE: keep the request high until the first cycle rw_busy=1, then drop it.
  - rwdone=1 -> NEXT. In the read phase, compare rdata with the expected word the same cycle; on mismatch, err_count+1 (saturating), error=1, pass_err=1.
  - TIMEOUT cycles without rwdone -> drop request; timeout=1, error=1, pass_err=1; treat the word as done (-> NEXT).
  - Never assert wrreq and rereq together.
- NEXT: advance the LFSR; addr+1.
  - At the last word (BASE_ADDR+BURST_LEN-1): addr wraps to BASE_ADDR, phase+1, -> GAP.
  - Otherwise -> ISSUE.
- GAP: count GAP_CYCLES, then phase+1 (mod 4) and LFSR=SEED.
  - Next phase 2 -> ISSUE.
  - Next phase 0 (pass complete): pass_count+1 if pass_err=0 (saturating); clear pass_err. Then if start=1, re-sample mode -> ISSUE; else -> IDLE.
- Expected/write word for offset i=addr-BASE_ADDR, truncated or zero-extended to DATA_W:
  - mode 0: addr.
  - mode 1: ~addr.
  - mode 2: 1<<(i mod DATA_W).
  - mode 3: 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1, state replicated to DATA_W.
- wdata is driven only in phase 0; elsewhere it is 0.
- A rwdone pulse outside WAITDONE is ignored.
- Mode changes mid-pass have no effect until the next write phase.

Optional Feature:
- Macro SDRAM_TEST_ERRLOG_EN.
- Defined: adds outputs first_err_addr (ADDR_W), first_err_exp (DATA_W), first_err_act (DATA_W). These capture the first mismatch after reset, are frozen afterwards, and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. Reset; GAP_CYCLES=8, BURST_LEN=16, mode 0, ideal controller model (busy 1 cycle after request, rwdone 3 cycles later), start=1 -> writes 0x0000..0x000F at addr 0..15; read-back matches; after one loop pass_count=1, err_count=0, error=0.
2. Mode 1 with the model corrupting rdata at addr 5 (bit 0 flipped) -> err_count=1, error=1, pass_count stays 0. With SDRAM_TEST_ERRLOG_EN: first_err_addr=5, first_err_exp=16'hFFFA, first_err_act=16'hFFFB.
3. Mode 2, DATA_W=8, BURST_LEN=10 -> write data 01,02,04,...,80,01,02; addr wraps to BASE_ADDR after offset 9.
4. Mode 3, model never asserts rwdone on the first read -> after TIMEOUT=1024 cycles, rereq drops, timeout=1, error=1, and the read proceeds to the next address.
5. Hold rw_busy=1 for 20 cycles while in ISSUE -> no request raised until busy falls; wrreq and rereq never both high.
6. Assert RST_N=0 mid read phase -> next cycle: requests low, counters 0, active=0. Drop start mid pass -> pass completes, FSM returns to IDLE.

Source files
------------

// File: rtl/sdram_pattern_tester.sv
// SDRAM pattern tester: writes a pattern over an address window, waits, reads it back and compares.
// Optional first-mismatch capture ports are enabled with the SDRAM_TEST_ERRLOG_EN macro.
module sdram_pattern_tester #(
    parameter int          ADDR_W     = 23,
    parameter int          DATA_W     = 16,
    parameter int          BASE_ADDR  = 0,
    parameter int          BURST_LEN  = 16,
    parameter int          GAP_CYCLES = 50000000,
    parameter int          TIMEOUT    = 1024,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic              CLOCK_50,
    input  logic              RST_N,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] addr,
    output logic              wrreq,
    output logic              rereq,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rwdone,
    input  logic              rw_busy,
    output logic [1:0]        phase,
    output logic              active,
    output logic              error,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [15:0]       pass_count
`ifdef SDRAM_TEST_ERRLOG_EN
    ,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_act
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(BASE_ADDR + BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
    localparam logic [DATA_W-1:0] WALK0   = DATA_W'(1);

    logic [2:0]        state;
    logic [1:0]        mode_r;
    logic [15:0]       lfsr;
    logic [DATA_W-1:0] walk;
    logic [DATA_W-1:0] walk_rot;
    logic [GW-1:0]     gcnt;
    logic [TW-1:0]     tcnt;
    logic              pass_err;
    logic [15:0]       lfsr_next;
    logic [DATA_W-1:0] addr_word;
    logic [DATA_W-1:0] lfsr_word;
    logic [DATA_W-1:0] exp_word;
    logic              mismatch;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting toward bit 0
    assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        if (b < ADDR_W) begin : g_a
            assign addr_word[b] = addr[b];
        end else begin : g_z
            assign addr_word[b] = 1'b0;
        end
        assign lfsr_word[b] = lfsr[b % 16];
    end

    always_comb begin
        walk_rot = '0;
        for (int b = 0; b < DATA_W; b++) walk_rot[(b + 1) % DATA_W] = walk[b];
    end

    always_comb begin
        case (mode_r)
            2'd0:    exp_word = addr_word;
            2'd1:    exp_word = ~addr_word;
            2'd2:    exp_word = walk;
            default: exp_word = lfsr_word;
        endcase
    end

    assign active   = (state != S_IDLE);
    assign wdata    = (active && phase == 2'd0) ? exp_word : '0;
    assign mismatch = (state == S_WAIT) && rwdone && (phase == 2'd2) && (rdata != exp_word);

    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            mode_r     <= 2'd0;
            addr       <= FIRST_A;
            phase      <= 2'd0;
            lfsr       <= SEED;
            walk       <= WALK0;
            gcnt       <= '0;
            tcnt       <= '0;
            wrreq      <= 1'b0;
            rereq      <= 1'b0;
            pass_err   <= 1'b0;
            error      <= 1'b0;
            timeout    <= 1'b0;
            err_count  <= 16'd0;
            pass_count <= 16'd0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    mode_r <= mode;
                    addr   <= FIRST_A;
                    phase  <= 2'd0;
                    lfsr   <= SEED;
                    walk   <= WALK0;
                    state  <= S_ISSUE;
                end
                S_ISSUE: if (!rw_busy) begin
                    if (phase == 2'd0) wrreq <= 1'b1;
                    else               rereq <= 1'b1;
                    tcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // the controller latches the request once it reports busy
                    if (rw_busy) begin
                        wrreq <= 1'b0;
                        rereq <= 1'b0;
                    end
                    if (rwdone) begin
                        wrreq <= 1'b0;
                        rereq <= 1'b0;
                        state <= S_NEXT;
                        if (mismatch) begin
                            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                            error    <= 1'b1;
                            pass_err <= 1'b1;
                        end
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        wrreq    <= 1'b0;
                        rereq    <= 1'b0;
                        timeout  <= 1'b1;
                        error    <= 1'b1;
                        pass_err <= 1'b1;
                        state    <= S_NEXT;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_NEXT: begin
                    lfsr <= lfsr_next;
                    if (addr == LAST_A) begin
                        addr  <= FIRST_A;
                        walk  <= WALK0;
                        phase <= phase + 2'd1;
                        gcnt  <= '0;
                        state <= S_GAP;
                    end else begin
                        addr  <= addr + ONE_A;
                        walk  <= walk_rot;
                        state <= S_ISSUE;
                    end
                end
                S_GAP: if (gcnt == GW'(GAP_CYCLES - 1)) begin
                    gcnt  <= '0;
                    phase <= phase + 2'd1;
                    lfsr  <= SEED;
                    if (phase == 2'd1) begin
                        state <= S_ISSUE;
                    end else begin
                        // read gap over: one full pass done
                        if (!pass_err && pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
                        pass_err <= 1'b0;
                        if (start) begin
                            mode_r <= mode;
                            state  <= S_ISSUE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end else begin
                    gcnt <= gcnt + GW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SDRAM_TEST_ERRLOG_EN
    logic err_logged;

    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            err_logged     <= 1'b0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_act  <= '0;
        end else if (mismatch && !err_logged) begin
            err_logged     <= 1'b1;
            first_err_addr <= addr;
            first_err_exp  <= exp_word;
            first_err_act  <= rdata;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Randomized scoreboard bench for sdram_pattern_tester: a controller/memory model feeds a
// monitor that checks every request against a queue of expected transactions.
module tb_sdram_pattern_tester;

    localparam int          AW   = 23;
    localparam int          DW   = 16;
    localparam int          BASE = 4;
    localparam int          BL   = 20;
    localparam int          GAP  = 8;
    localparam int          TO   = 1024;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          CLOCK_50 = 1'b0;
    logic          RST_N    = 1'b0;
    logic          start    = 1'b0;
    logic [1:0]    mode     = 2'd0;
    logic [AW-1:0] addr;
    logic          wrreq, rereq;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata    = '0;
    logic          rwdone   = 1'b0;
    logic          rw_busy  = 1'b0;
    logic [1:0]    phase;
    logic          active, error, timeout;
    logic [15:0]   err_count, pass_count;
`ifdef SDRAM_TEST_ERRLOG_EN
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_exp, first_err_act;
`endif

    sdram_pattern_tester #(
        .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE), .BURST_LEN(BL),
        .GAP_CYCLES(GAP), .TIMEOUT(TO), .SEED(SEED)
    ) dut (
        .CLOCK_50(CLOCK_50), .RST_N(RST_N), .start(start), .mode(mode),
        .addr(addr), .wrreq(wrreq), .rereq(rereq), .wdata(wdata), .rdata(rdata),
        .rwdone(rwdone), .rw_busy(rw_busy), .phase(phase), .active(active),
        .error(error), .timeout(timeout), .err_count(err_count), .pass_count(pass_count)
`ifdef SDRAM_TEST_ERRLOG_EN
        , .first_err_addr(first_err_addr), .first_err_exp(first_err_exp),
        .first_err_act(first_err_act)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } txn_t;

    txn_t          sb[$];
    int            n_vec = 0;
    int            n_bad = 0;

    // fault injection and expected status
    bit            corrupt_en = 0, hang_en = 0, spur_en = 0;
    logic [AW-1:0] corrupt_addr = '0, hang_addr = '0;
    logic [DW-1:0] corrupt_mask = '0;
    int            fbusy = 0;
    int            e_err = 0, e_pass = 0;
    bit            e_error = 0, e_to = 0, e_first_v = 0;
    logic [AW-1:0] e_first_a = '0;
    logic [DW-1:0] e_first_e = '0, e_first_x = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // pattern word at offset i, straight from the pattern definitions
    function automatic logic [DW-1:0] exp_word(input int m, input int i);
        logic [15:0] s;
        logic        fb;
        s = SEED;
        case (m)
            0: return DW'(BASE + i);
            1: return ~DW'(BASE + i);
            2: return DW'(1) << (i % DW);
            default: begin
                for (int k = 0; k < i; k++) begin
                    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
                    s  = {fb, s[15:1]};
                end
                return s;
            end
        endcase
    endfunction

    task automatic push_pass(input int m);
        txn_t t;
        for (int i = 0; i < BL; i++) begin
            t.wr = 1; t.a = AW'(BASE + i); t.d = exp_word(m, i); sb.push_back(t);
        end
        for (int i = 0; i < BL; i++) begin
            t.wr = 0; t.a = AW'(BASE + i); t.d = '0; sb.push_back(t);
        end
    endtask

    task automatic account(input int m);
        bit mism;
        mism = corrupt_en && !(hang_en && hang_addr == corrupt_addr);
        if (mism) e_err++;
        if (!mism && !hang_en) e_pass++;
        else e_error = 1;
        if (hang_en) e_to = 1;
        if (mism && !e_first_v) begin
            e_first_v = 1;
            e_first_a = corrupt_addr;
            e_first_e = exp_word(m, int'(corrupt_addr) - BASE);
            e_first_x = e_first_e ^ corrupt_mask;
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".err_count"}, err_count, e_err);
        chk({tag, ".pass_count"}, pass_count, e_pass);
        chk({tag, ".error"}, error, e_error);
        chk({tag, ".timeout"}, timeout, e_to);
`ifdef SDRAM_TEST_ERRLOG_EN
        chk({tag, ".first_err_addr"}, first_err_addr, e_first_a);
        chk({tag, ".first_err_exp"}, first_err_exp, e_first_e);
        chk({tag, ".first_err_act"}, first_err_act, e_first_x);
`endif
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".wrreq"}, wrreq, 0);
        chk({tag, ".rereq"}, rereq, 0);
        chk({tag, ".addr"}, addr, BASE);
        chk({tag, ".wdata"}, wdata, 0);
        chk({tag, ".phase"}, phase, 0);
        chk({tag, ".active"}, active, 0);
        check_status(tag);
    endtask

    function automatic bit cond(input int c);
        case (c)
            0: return active == 1'b1;
            1: return active == 1'b0;
            2: return phase == 2'd2;
            3: return phase == 2'd3;
            default: return phase == 2'd0 && active;
        endcase
    endfunction

    task automatic wait_for(input int c, input int bound, input string name);
        int k;
        k = 0;
        while (!cond(c) && k < bound) begin
            @(negedge CLOCK_50);
            k++;
        end
        chk(name, cond(c), 1);
    endtask

    task automatic one_pass(input int m, input bit busy_hold);
        @(negedge CLOCK_50);
        mode  = 2'(m);
        start = 1'b1;
        push_pass(m);
        wait_for(0, 10, "start_active");
        start = 1'b0;
        mode  = 2'($urandom);   // ignored until the next write phase
        if (busy_hold) fbusy = 20;
        wait_for(1, 20000, "pass_done");
        account(m);
        check_status($sformatf("pass_m%0d", m));
    endtask

    task automatic random_faults();
        corrupt_en   = ($urandom_range(0, 2) == 0);
        corrupt_addr = AW'(BASE + $urandom_range(0, BL - 1));
        corrupt_mask = DW'(1) << $urandom_range(0, DW - 1);
        hang_en      = ($urandom_range(0, 4) == 0);
        hang_addr    = AW'(BASE + $urandom_range(0, BL - 1));
    endtask

    // controller + memory model, also the monitor that pops the scoreboard
    int            cst = 0, wcnt = 0, dcnt = 0, hcnt = 0;
    bit            cur_wr = 0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] mem [int];

    always @(negedge CLOCK_50) begin
        txn_t e;
        if (!RST_N) begin
            cst = 0; rw_busy = 0; rwdone = 0; fbusy = 0;
        end else begin
            rwdone = 0;
            if (wrreq && rereq) chk("req_exclusive", 1, 0);
            case (cst)
                0: if (wrreq || rereq) begin
                    chk("req_while_busy", rw_busy, 0);
                    if (sb.size() == 0) begin
                        chk("unexpected_request", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("req_kind", wrreq, e.wr);
                        chk("req_addr", addr, e.a);
                        chk("req_wdata", wdata, e.d);
                    end
                    cur_wr   = wrreq;
                    cur_addr = addr;
                    if (wrreq) mem[int'(addr)] = wdata;
                    if (rereq && hang_en && addr == hang_addr) begin
                        cst = 3; hcnt = 1;
                    end else begin
                        cst = 1; wcnt = $urandom_range(1, 2);
                    end
                end else if (fbusy > 0) begin
                    rw_busy = 1; fbusy--;
                end else begin
                    rw_busy = 0;
                    if (spur_en && $urandom_range(0, 15) == 0) begin
                        rwdone = 1; rdata = DW'($urandom);
                    end
                end
                1: begin
                    wcnt--;
                    if (wcnt == 0) begin rw_busy = 1; dcnt = 3; cst = 2; end
                end
                2: begin
                    dcnt--;
                    if (dcnt == 0) begin
                        rwdone = 1;
                        if (cur_wr || !mem.exists(int'(cur_addr))) rdata = DW'($urandom);
                        else rdata = mem[int'(cur_addr)] ^
                                     ((corrupt_en && cur_addr == corrupt_addr) ? corrupt_mask : '0);
                        cst = 4;
                    end
                end
                4: begin rw_busy = 0; cst = 0; end
                default: if (rereq) begin
                    hcnt++;
                    if (hcnt > TO + 8) begin chk("timeout_release", hcnt, TO); cst = 0; end
                end else begin
                    chk("timeout_len", hcnt, TO);
                    cst = 0;
                end
            endcase
        end
    end

    initial begin
        #1_600_000;
        $display("FAIL watchdog: simulation did not finish (n_vec=%0d)", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLOCK_50);
        check_reset("init");
        RST_N = 1'b1;

        one_pass(0, 0);                                  // plain address pattern
        corrupt_en = 1; corrupt_addr = AW'(5); corrupt_mask = DW'(1);
        one_pass(1, 0);                                  // ~addr with bit 0 flipped at addr 5
        corrupt_en = 0;
        one_pass(2, 0);                                  // walking one, wraps past DATA_W
        hang_en = 1; hang_addr = AW'(BASE);
        one_pass(3, 0);                                  // LFSR, first read never completes
        hang_en = 0;
        one_pass($urandom_range(0, 3), 1);               // busy held while issuing

        spur_en = 1;
        for (int p = 0; p < 10; p++) begin
            random_faults();
            one_pass($urandom_range(0, 3), $urandom_range(0, 3) == 0);
        end

        // start held across a pass boundary: a second pass follows without IDLE
        random_faults();
        begin
            int m2;
            m2 = $urandom_range(0, 3);
            @(negedge CLOCK_50);
            mode = 2'(m2); start = 1'b1;
            push_pass(m2); push_pass(m2);
            wait_for(3, 20000, "dbl_gap");
            wait_for(4, 200, "dbl_second_pass");
            start = 1'b0;
            wait_for(1, 20000, "dbl_done");
            account(m2); account(m2);
            check_status("double");
        end

        // reset in the middle of a read phase
        corrupt_en = 0; hang_en = 0;
        @(negedge CLOCK_50);
        mode = 2'($urandom); start = 1'b1;
        push_pass(int'(mode));
        wait_for(0, 10, "rst_start");
        start = 1'b0;
        wait_for(2, 20000, "rst_read_phase");
        repeat ($urandom_range(1, 30)) @(negedge CLOCK_50);
        RST_N = 1'b0;
        @(negedge CLOCK_50);
        sb.delete();
        e_err = 0; e_pass = 0; e_error = 0; e_to = 0;
        e_first_v = 0; e_first_a = '0; e_first_e = '0; e_first_x = '0;
        check_reset("midreset");
        @(negedge CLOCK_50);
        RST_N = 1'b1;

        spur_en = 0;
        one_pass(0, 0);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
